logic_basic_queue_level: RTL and testbench

//  Parametrised successor of the basic stream queue (FIFO): AXI4-Stream rx -> tx buffering with

---
 rtl/logic_basic_queue_level.sv | 124 ++++++++++++
 tb/tb_logic_basic_queue_level.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/logic_basic_queue_level.sv
// Stream queue: AXI4-Stream rx -> tx buffer with fill level, almost-full/almost-empty flags,
// synchronous flush and optional store-and-forward packet gating keyed on tlast.
module logic_basic_queue_level #(
    parameter int WIDTH        = 1,
    parameter int CAPACITY     = 256,
    parameter int ALMOST_FULL  = CAPACITY - 2,
    parameter int ALMOST_EMPTY = 2,
    parameter int PACKET_MODE  = 0
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              rx_tvalid,
    input  logic                              rx_tlast,
    input  logic [WIDTH-1:0]                  rx_tdata,
    output logic                              rx_tready,
    input  logic                              tx_tready,
    output logic                              tx_tvalid,
    output logic                              tx_tlast,
    output logic [WIDTH-1:0]                  tx_tdata,
    output logic [$clog2(CAPACITY+1)-1:0]     level,
    output logic                              almost_full,
    output logic                              almost_empty
);

    localparam int LW = $clog2(CAPACITY + 1);
    localparam int PW = $clog2(CAPACITY);
    localparam logic [PW-1:0] PTR_LAST = PW'(CAPACITY - 1);
    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_FULL = LW'(CAPACITY);
    localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] LVL_AE   = LW'(ALMOST_EMPTY);

    if (CAPACITY < 4 || ALMOST_FULL < 1 || ALMOST_FULL > CAPACITY ||
        ALMOST_EMPTY < 0 || ALMOST_EMPTY > CAPACITY - 1) begin : g_param_check
        $error("logic_basic_queue_level: illegal parameter combination");
    end

    // Pointer advance with explicit wrap so non-power-of-2 capacities work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [WIDTH:0]   mem_r [CAPACITY];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [LW-1:0]    level_r, level_s, packets_r, packets_s;
    logic             ready_r, valid_r, valid_s, last_r, release_r, release_s;
    logic             af_r, ae_r, wr_s, rd_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH:0]   head_s;

    // flush must refuse the concurrent beat, so it gates the registered ready directly.
    assign rx_tready    = ready_r & ~flush;
    assign wr_s         = rx_tvalid & rx_tready;
    assign rd_s         = valid_r & tx_tready;
    assign tx_tvalid    = valid_r;
    assign tx_tlast     = last_r;
    assign tx_tdata     = data_r;
    assign level        = level_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;

    // Next-state for pointers, counters, packet release and the head-of-queue output stage.
    always_comb begin
        wr_ptr_s  = wr_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_s  = rd_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        level_s   = level_r + LW'(wr_s) - LW'(rd_s);
        packets_s = packets_r + LW'(wr_s & rx_tlast) - LW'(rd_s & last_r);
        // A full queue holding no tlast can never complete its packet: release it.
        release_s = ((level_s == LVL_FULL) && (packets_s == LVL_ZERO)) ? 1'b1 :
                    (rd_s && last_r) ? 1'b0 : release_r;
        head_s    = {(WIDTH+1){1'b0}};
        if (level_s == LVL_ZERO) begin
            head_s = {(WIDTH+1){1'b0}};
        end else if (wr_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = {rx_tlast, rx_tdata};
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
        if (PACKET_MODE != 0) begin
            valid_s = (level_s != LVL_ZERO) &&
                      ((packets_s != LVL_ZERO) || (level_s == LVL_FULL) || release_s);
        end else begin
            valid_s = (level_s != LVL_ZERO);
        end
    end

    // Storage write port; contents are meaningless once pointers are cleared.
    always_ff @(posedge aclk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {rx_tlast, rx_tdata};
        end
    end

    // State and registered outputs; reset overrides flush, flush overrides traffic.
    always_ff @(posedge aclk) begin
        if (reset || flush) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            level_r   <= LVL_ZERO;
            packets_r <= LVL_ZERO;
            release_r <= 1'b0;
            ready_r   <= ~reset;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            data_r    <= {WIDTH{1'b0}};
            af_r      <= 1'b0;
            ae_r      <= 1'b1;
        end else begin
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            level_r   <= level_s;
            packets_r <= packets_s;
            release_r <= release_s;
            ready_r   <= (level_s != LVL_FULL);
            valid_r   <= valid_s;
            last_r    <= head_s[WIDTH];
            data_r    <= head_s[WIDTH-1:0];
            af_r      <= (level_s >= LVL_AF);
            ae_r      <= (level_s <= LVL_AE);
        end
    end

endmodule

// File: tb/tb_logic_basic_queue_level.sv
// Drives a word-mode and a packet-mode queue (CAPACITY=5, WIDTH=8) with shared stimulus and
// compares both against a shift-buffer reference model every cycle.
module tb_logic_basic_queue_level;

    localparam int CAP = 5;
    localparam int AF  = 3;
    localparam int AE  = 2;

    logic       aclk = 1'b0;
    logic       reset, flush, rx_tvalid, rx_tlast, tx_tready;
    logic [7:0] rx_tdata;
    logic       rdy0, vld0, tl0, af0, ae0, rdy1, vld1, tl1, af1, ae1;
    logic [7:0] dat0, dat1;
    logic [2:0] lvl0, lvl1;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] mbuf [2][CAP];
    int         mcnt [2];
    bit         mrel [2];
    bit         mrdy [2];

    always #5 aclk = ~aclk;

    logic_basic_queue_level #(.WIDTH(8), .CAPACITY(CAP), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE),
                              .PACKET_MODE(0)) u_word (
        .aclk(aclk), .reset(reset), .flush(flush), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tready(rdy0), .tx_tready(tx_tready), .tx_tvalid(vld0),
        .tx_tlast(tl0), .tx_tdata(dat0), .level(lvl0), .almost_full(af0), .almost_empty(ae0));

    logic_basic_queue_level #(.WIDTH(8), .CAPACITY(CAP), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE),
                              .PACKET_MODE(1)) u_pkt (
        .aclk(aclk), .reset(reset), .flush(flush), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tready(rdy1), .tx_tready(tx_tready), .tx_tvalid(vld1),
        .tx_tlast(tl1), .tx_tdata(dat1), .level(lvl1), .almost_full(af1), .almost_empty(ae1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_tlast(input int m);
        int n = 0;
        for (int i = 0; i < mcnt[m]; i++) if (mbuf[m][i][8]) n++;
        return n;
    endfunction

    // Mode 0 shows any stored word; mode 1 needs a whole packet, a full queue or a released packet.
    function automatic bit m_valid(input int m);
        if (mcnt[m] == 0) return 1'b0;
        if (m == 0) return 1'b1;
        return (n_tlast(m) > 0) || (mcnt[m] == CAP) || mrel[m];
    endfunction

    task automatic model_step(input int m);
        bit wr, rd, popped_last;
        if (reset) begin
            mcnt[m] = 0; mrel[m] = 1'b0; mrdy[m] = 1'b0;
        end else if (flush) begin
            mcnt[m] = 0; mrel[m] = 1'b0; mrdy[m] = 1'b1;
        end else begin
            wr = rx_tvalid && mrdy[m];
            rd = m_valid(m) && tx_tready;
            popped_last = 1'b0;
            if (rd) begin
                popped_last = mbuf[m][0][8];
                for (int i = 0; i < CAP - 1; i++) mbuf[m][i] = mbuf[m][i+1];
                mcnt[m]--;
            end
            if (wr) begin
                mbuf[m][mcnt[m]] = {rx_tlast, rx_tdata};
                mcnt[m]++;
            end
            if (popped_last) mrel[m] = 1'b0;
            if (mcnt[m] == CAP && n_tlast(m) == 0) mrel[m] = 1'b1;
            mrdy[m] = (mcnt[m] < CAP);
        end
    endtask

    task automatic check_dut(input int m, input logic rdy, input logic vld, input logic tl,
                             input logic [7:0] dat, input logic [2:0] lvl, input logic af,
                             input logic ae);
        string p;
        p = (m == 0) ? "word" : "pkt";
        check({p, "_rx_tready"}, 32'(rdy), 32'(mrdy[m] && !flush));
        check({p, "_tx_tvalid"}, 32'(vld), 32'(m_valid(m)));
        check({p, "_level"}, 32'(lvl), 32'(mcnt[m]));
        check({p, "_almost_full"}, 32'(af), 32'(mcnt[m] >= AF));
        check({p, "_almost_empty"}, 32'(ae), 32'(mcnt[m] <= AE));
        if (m_valid(m)) begin
            check({p, "_tx_tdata"}, 32'(dat), 32'(mbuf[m][0][7:0]));
            check({p, "_tx_tlast"}, 32'(tl), 32'(mbuf[m][0][8]));
        end
    endtask

    // One clock: advance the model with the inputs just driven, then sample away from the edge.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge aclk);
        @(negedge aclk);
        check_dut(0, rdy0, vld0, tl0, dat0, lvl0, af0, ae0);
        check_dut(1, rdy1, vld1, tl1, dat1, lvl1, af1, ae1);
    endtask

    task automatic drive(input bit v, input bit l, input logic [7:0] d, input bit tr, input bit fl);
        rx_tvalid = v; rx_tlast = l; rx_tdata = d; tx_tready = tr; flush = fl;
        cycle();
    endtask

    initial begin
        bit acc;
        int rdy_pct;
        reset = 1'b1; flush = 1'b0; rx_tvalid = 1'b1; rx_tlast = 1'b0; rx_tdata = 8'h5A;
        tx_tready = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; mrel[m] = 1'b0; mrdy[m] = 1'b0;
        end
        @(negedge aclk);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("post_reset_ready", 32'(rdy0), 32'd1);

        // Fill to capacity with the consumer stalled, then drain.
        for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        check("fill_level", 32'(lvl0), 32'd5);
        check("fill_ready", 32'(rdy0), 32'd0);
        check("fill_almost_full", 32'(af0), 32'd1);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'd99, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 100; i++) drive(1'b1, (i % 4) == 3, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with three words stored and a concurrent write.
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
        check("flush_level", 32'(lvl0), 32'd0);
        check("flush_valid", 32'(vld0), 32'd0);
        drive(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        check("flush_first_word", 32'(dat0), 32'hAA);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Three-word packet with idle gaps between beats.
        drive(1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        check("pkt_gated", 32'(vld1), 32'd0);
        drive(1'b1, 1'b1, 8'd3, 1'b1, 1'b0);
        check("pkt_released", 32'(vld1), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Seven-word packet into a five-word queue must cut through at full.
        for (int i = 1; i <= 7; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                acc = mrdy[1];
                drive(1'b1, i == 7, 8'(8'd100 + i), 1'b1, 1'b0);
            end
            check("long_pkt_accept", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("long_pkt_drained", 32'(lvl1), 32'd0);

        // Random traffic with varying back-pressure, rare flushes and rare resets.
        rdy_pct = 70;
        for (int i = 0; i < 8000; i++) begin
            if (i % 500 == 0) rdy_pct = 20 + int'($urandom_range(0, 70));
            reset = ($urandom_range(0, 1999) == 0);
            drive($urandom_range(0, 99) < 75, $urandom_range(0, 4) == 0, 8'($urandom),
                  $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 299) == 0);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
